// File: rtl/data_out_read.sv
// Streams slices out of the 6-bank ping-pong BRAM set as an AXI4-Stream master.
// Optional DATA_OUT_TUSER_EN adds M_AXIS_TUSER carrying the bank index of each beat.
module data_out_read #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9,
   parameter int BANK_NUM   = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [2:0]                     layer,
   input  logic [7:0]                     row_deep,
   input  logic [3:0]                     group_num,
   input  logic [9:0]                     slice_num,
   output logic                           busy,
   output logic                           done,
   output logic [BANK_NUM-1:0]            en_rd,
   output logic [ADDR_WIDTH-1:0]          addr_rd,
   input  logic [BANK_NUM*DATA_WIDTH-1:0] data_rd,
   output logic                           M_AXIS_TVALID,
   input  logic                           M_AXIS_TREADY,
   output logic [DATA_WIDTH-1:0]          M_AXIS_TDATA,
`ifdef DATA_OUT_TUSER_EN
   output logic [2:0]                     M_AXIS_TUSER,
`endif
   output logic                           M_AXIS_TLAST
);

`ifdef DATA_OUT_TUSER_EN
   localparam int ENTRY_W = DATA_WIDTH + 4;
`else
   localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

   typedef enum logic [1:0] {IDLE, CONFIG, RUN, DONE} state_t;

   state_t              state_q, state_d;
   logic [7:0]          rowDeep_q, rowDeep_d;
   logic [3:0]          groupNum_q, groupNum_d;
   logic [9:0]          sliceNum_q, sliceNum_d;
   logic [8:0]          offset_q, offset_d;
   logic [7:0]          row_q, row_d;
   logic [2:0]          bank_q, bank_d;
   logic [3:0]          group_q, group_d;
   logic [9:0]          slice_q, slice_d;
   logic                issueDone_q, issueDone_d;
   logic                inFlight_q, inFlight_d;
   logic                inflightLast_q, inflightLast_d;
   logic [2:0]          inflightBank_q, inflightBank_d;
   logic [ENTRY_W-1:0]  mem_q [2];
   logic [ENTRY_W-1:0]  mem_d [2];
   logic                wrPtr_q, wrPtr_d;
   logic                rdPtr_q, rdPtr_d;
   logic [1:0]          fifoCnt_q, fifoCnt_d;

   logic                pop;
   logic                issue;
   logic                issueLast;
   logic                sliceWrap;
   logic [2:0]          pending;
   logic [8:0]          layerOffset;
   logic [12:0]         addrSum;
   logic [ENTRY_W-1:0]  pushEntry;
   logic [ENTRY_W-1:0]  headEntry;

   always_comb begin
      case (layer)
         3'd1:    layerOffset = 9'd256;
         3'd2:    layerOffset = 9'd128;
         3'd3:    layerOffset = 9'd64;
         3'd4:    layerOffset = 9'd32;
         default: layerOffset = 9'd0;
      endcase
   end

   // A read may only be launched if the FIFO is guaranteed a free slot when its data lands.
   assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;
   assign pending   = {1'b0, fifoCnt_q} + {2'b0, inFlight_q};
   assign issue     = (state_q == RUN) && !issueDone_q && (pending < (3'd2 + {2'b0, pop}));
   assign issueLast = (row_q == rowDeep_q) && (bank_q == 3'(BANK_NUM - 1))
                      && (group_q == groupNum_q - 4'd1);
   assign sliceWrap = (slice_q == sliceNum_q - 10'd1);

   assign addrSum = 13'({slice_q[0], 8'd0}) + (13'(group_q) * 13'(offset_q)) + 13'(row_q);
   assign addr_rd = addrSum[ADDR_WIDTH-1:0];
   assign en_rd   = issue ? (BANK_NUM'(1) << bank_q) : '0;

`ifdef DATA_OUT_TUSER_EN
   assign pushEntry = {inflightBank_q, inflightLast_q,
                       data_rd[int'(inflightBank_q)*DATA_WIDTH +: DATA_WIDTH]};
`else
   assign pushEntry = {inflightLast_q, data_rd[int'(inflightBank_q)*DATA_WIDTH +: DATA_WIDTH]};
`endif

   assign headEntry     = mem_q[rdPtr_q];
   assign M_AXIS_TVALID = (fifoCnt_q != 2'd0);
   assign M_AXIS_TDATA  = headEntry[DATA_WIDTH-1:0];
   assign M_AXIS_TLAST  = headEntry[DATA_WIDTH];
`ifdef DATA_OUT_TUSER_EN
   assign M_AXIS_TUSER  = headEntry[DATA_WIDTH+3:DATA_WIDTH+1];
`endif

   assign busy = (state_q == CONFIG) || (state_q == RUN);
   assign done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONFIG;
         CONFIG:  state_d = RUN;
         RUN:     if (issueDone_q && !inFlight_q && (fifoCnt_q == 2'd1) && pop) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Issue-side counters walk row, bank, group, slice with row innermost.
   always_comb begin
      rowDeep_d      = rowDeep_q;
      groupNum_d     = groupNum_q;
      sliceNum_d     = sliceNum_q;
      offset_d       = offset_q;
      row_d          = row_q;
      bank_d         = bank_q;
      group_d        = group_q;
      slice_d        = slice_q;
      issueDone_d    = issueDone_q;
      inFlight_d     = issue;
      inflightLast_d = issue ? issueLast : inflightLast_q;
      inflightBank_d = issue ? bank_q : inflightBank_q;
      if ((state_q == IDLE) && start) begin
         rowDeep_d  = row_deep;
         groupNum_d = (group_num == 4'd0) ? 4'd1 : group_num;
         sliceNum_d = (slice_num == 10'd0) ? 10'd1 : slice_num;
         offset_d   = layerOffset;
      end
      if (state_q == CONFIG) begin
         row_d       = 8'd0;
         bank_d      = 3'd0;
         group_d     = 4'd0;
         slice_d     = 10'd0;
         issueDone_d = 1'b0;
      end else if (issue) begin
         row_d = row_q + 8'd1;
         if (row_q == rowDeep_q) begin
            row_d  = 8'd0;
            bank_d = bank_q + 3'd1;
            if (bank_q == 3'(BANK_NUM - 1)) begin
               bank_d  = 3'd0;
               group_d = group_q + 4'd1;
               if (group_q == groupNum_q - 4'd1) begin
                  group_d = 4'd0;
                  slice_d = slice_q + 10'd1;
                  if (sliceWrap) begin
                     slice_d     = 10'd0;
                     issueDone_d = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      fifoCnt_d = fifoCnt_q;
      if (inFlight_q) begin
         mem_d[wrPtr_q] = pushEntry;
         wrPtr_d        = ~wrPtr_q;
      end
      if (pop) rdPtr_d = ~rdPtr_q;
      fifoCnt_d = fifoCnt_q + {1'b0, inFlight_q} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         rowDeep_q      <= '0;
         groupNum_q     <= '0;
         sliceNum_q     <= '0;
         offset_q       <= '0;
         row_q          <= '0;
         bank_q         <= '0;
         group_q        <= '0;
         slice_q        <= '0;
         issueDone_q    <= 1'b0;
         inFlight_q     <= 1'b0;
         inflightLast_q <= 1'b0;
         inflightBank_q <= '0;
         mem_q[0]       <= '0;
         mem_q[1]       <= '0;
         wrPtr_q        <= 1'b0;
         rdPtr_q        <= 1'b0;
         fifoCnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         rowDeep_q      <= rowDeep_d;
         groupNum_q     <= groupNum_d;
         sliceNum_q     <= sliceNum_d;
         offset_q       <= offset_d;
         row_q          <= row_d;
         bank_q         <= bank_d;
         group_q        <= group_d;
         slice_q        <= slice_d;
         issueDone_q    <= issueDone_d;
         inFlight_q     <= inFlight_d;
         inflightLast_q <= inflightLast_d;
         inflightBank_q <= inflightBank_d;
         mem_q[0]       <= mem_d[0];
         mem_q[1]       <= mem_d[1];
         wrPtr_q        <= wrPtr_d;
         rdPtr_q        <= rdPtr_d;
         fifoCnt_q      <= fifoCnt_d;
      end
   end

endmodule
